// File: rtl/sr_cmd_driver.sv
// Turns "make Q equal level L" requests into legal s/r pulses for a clocked SR flop, confirming via q_fb.
// Optional macro SR_DRV_HOLD_EN: hold s/r until q_fb matches (or PULSE_W+TIMEOUT cycles), skipping WAIT.
module sr_cmd_driver #(
  parameter int PULSE_W = 2,
  parameter int TIMEOUT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic done,
  output logic err
);

`ifdef SR_DRV_HOLD_EN
  localparam int CNT_MAX = PULSE_W + TIMEOUT;
`else
  localparam int CNT_MAX = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
`ifdef SR_DRV_HOLD_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(PULSE_W + TIMEOUT - 1);
`else
  localparam logic [CW-1:0] PW_LAST = CW'(PULSE_W - 1);
`endif

  typedef enum logic [1:0] {IDLE, PULSE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lvl, lvl_nxt;
  logic          s_nxt, r_nxt, done_nxt, err_nxt;
  logic          match;

  assign match     = (q_fb == lvl);
  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lvl_nxt   = lvl;
    s_nxt     = s;
    r_nxt     = r;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        lvl_nxt = req_level;
        cnt_nxt = '0;
        if (q_fb == req_level) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = PULSE;
          s_nxt     = req_level;
          r_nxt     = ~req_level;
        end
      end
`ifdef SR_DRV_HOLD_EN
      PULSE: if (match || cnt == HOLD_LAST) begin
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        state_nxt = DONE;
        done_nxt  = 1'b1;
        err_nxt   = ~match;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
`else
      // Fixed width: an early q_fb match does not cut the pulse short.
      PULSE: if (cnt == PW_LAST) begin
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
`endif
      // Match is checked before expiry so a match on the last edge still succeeds.
      WAIT: if (match) begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
        cnt_nxt   = '0;
      end else if (cnt == TO_LAST) begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
        err_nxt   = 1'b1;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      lvl   <= 1'b0;
      s     <= 1'b0;
      r     <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lvl   <= lvl_nxt;
      s     <= s_nxt;
      r     <= r_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed + randomized bench for sr_cmd_driver; q_fb is scripted per command and
// expected timing is derived arithmetically from the command's q_fb switch edge.
module tb_sr_cmd_driver;
  localparam int PW = 2;
  localparam int TO = 4;

  logic clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_level = 1'b0, q_fb = 1'b0;
  logic req_ready, s, r, busy, done, err;
  int   vectors = 0, miscompares = 0;

  sr_cmd_driver #(.PULSE_W(PW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_level(req_level),
    .req_ready(req_ready), .q_fb(q_fb), .s(s), .r(r), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    check("inv_s_and_r", s & r, 1'b0);
    check("inv_busy_not_ready", busy, ~req_ready);
  end

  // t = first edge index (E0 = 0) at which q_fb equals the target; t<=0 means already there.
  function automatic int done_edge(input int t, output bit tout);
    int first;
    tout = 1'b0;
    if (t <= 0) return 0;
`ifdef SR_DRV_HOLD_EN
    first = t;
`else
    first = (t < PW + 1) ? PW + 1 : t;
`endif
    if (first <= PW + TO) return first;
    tout = 1'b1;
    return PW + TO;
  endfunction

  task automatic run_cmd(input logic lvl, input int t, input bit keep_valid, input string tag);
    int d, pend;
    bit tout, act;
    d = done_edge(t, tout);
`ifdef SR_DRV_HOLD_EN
    pend = (t <= 0) ? 0 : d;
`else
    pend = (t <= 0) ? 0 : PW;
`endif
    check($sformatf("%s_ready_pre", tag), req_ready, 1'b1);
    req_valid = 1'b1;
    req_level = lvl;
    q_fb      = (t <= 0) ? lvl : ~lvl;
    for (int n = 0; n <= d + 1; n++) begin
      @(negedge clk);
      if (!keep_valid) req_valid = 1'b0;
      else req_level = 1'($urandom_range(0, 1));
      act = (t > 0) && (n < pend);
      check($sformatf("%s_s_c%0d", tag, n), s, act & lvl);
      check($sformatf("%s_r_c%0d", tag, n), r, act & ~lvl);
      check($sformatf("%s_done_c%0d", tag, n), done, n == d);
      check($sformatf("%s_err_c%0d", tag, n), err, (n == d) && tout);
      check($sformatf("%s_busy_c%0d", tag, n), busy, n <= d);
      q_fb = (n + 1 >= t) ? lvl : ~lvl;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_s", s, 1'b0);
    check("rst_r", r, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);

    run_cmd(1'b1, 2, 1'b0, "set_ok");
    run_cmd(1'b1, 0, 1'b0, "already");
    run_cmd(1'b1, 99, 1'b0, "timeout");
    run_cmd(1'b0, 2, 1'b0, "clr_ok");
    run_cmd(1'b1, PW + TO, 1'b0, "last_edge");
    run_cmd(1'b0, PW + TO + 1, 1'b0, "just_late");
    run_cmd(1'b1, 1, 1'b0, "early_match");
    run_cmd(1'b0, 0, 1'b0, "already0");

    // reset in the middle of a pulse
    req_valid = 1'b1; req_level = 1'b0; q_fb = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_r_before", r, 1'b1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_s", s, 1'b0);
    check("mid_r", r, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_done", done, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("mid_no_done", done, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1'b1);
    run_cmd(1'b0, 3, 1'b0, "post_rst");

    // continuous valid, alternating levels
    run_cmd(1'b1, 2, 1'b1, "b2b_1");
    run_cmd(1'b0, 3, 1'b1, "b2b_0");
    run_cmd(1'b1, 2, 1'b1, "b2b_2");
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_idle", busy, 1'b0);

    for (int i = 0; i < 16; i++) begin
      run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, PW + TO + 2)),
              1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end
    req_valid = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sr_cmd_driver.md
Name: sr_cmd_driver

Overview:
Command-side driver for the team's clocked SR flip-flop: converts "make Q equal level L" requests into legal s/r pulses.
- Watches the flop's q output (q_fb) to confirm the change took effect.
- Reports completion, or a timeout error, to the requester.
- Sits between control logic and an SR_ff instance; both are on the same clk.
- Never drives s=r=1.

Parameters:
PULSE_W, 2, cycles s or r is held high per command (>=1)
TIMEOUT, 4, max cycles to wait for q_fb to match after the pulse ends (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  command request
req_level  input  1  target Q level (1=set, 0=reset)
req_ready  output  1  high when a command can be accepted (IDLE only)
q_fb  input  1  q from the driven SR flop, same clock domain, no synchroniser
s  output  1  set drive to SR flop, registered
r  output  1  reset drive to SR flop, registered
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion strobe, registered
err  output  1  valid with done; 1 = timeout, 0 = success

Behaviour:
- Reset (async, reset=1):
  - state=IDLE; s=0, r=0, done=0, err=0, counters=0.
  - req_ready=1 once reset is released.
  - Asserting reset mid-operation drops s/r immediately, without waiting for a clock edge.
- States: IDLE, PULSE, WAIT, DONE.
- Accept:
  - A command is accepted at edge E0 when req_valid=1 and req_ready=1.
  - req_level is latched into lvl at E0.
  - req_valid is ignored outside IDLE; there is no queueing.
- IDLE, at E0:
  - If q_fb==req_level: go to DONE with err=0. No pulse is issued.
  - Else: go to PULSE, cnt=0. s=lvl and r=~lvl are registered high from E0.
- PULSE:
  - The active line is held high for exactly PULSE_W cycles.
  - At E_PULSE_W: s=r=0, go to WAIT, cnt=0.
  - A q_fb match during PULSE does not shorten the pulse.
- WAIT:
  - q_fb is sampled each edge.
  - On a match: go to DONE with err=0.
  - If no match by the TIMEOUT-th sampling edge: go to DONE with err=1.
  - A match on the TIMEOUT-th edge counts as success.
- DONE:
  - done=1 for exactly one cycle; err is valid in the same cycle.
  - Next edge: go to IDLE and clear err.
  - req_ready=0 during DONE.
- Latencies, counted from the accept edge E0:
  - Success: done rises after E_(PULSE_W+1).
  - Already at level: done rises after E0.
  - Timeout: done rises after E_(PULSE_W+TIMEOUT).
- Invariants:
  - s&r==0 always.
  - s|r is high only in PULSE.
  - req_ready == (state==IDLE).
  - busy == ~req_ready.
- Counter width: $clog2(max(PULSE_W,TIMEOUT)+1). The counter must not wrap within a state.
- Back-to-back commands: minimum spacing is one IDLE cycle after DONE.

Optional Feature:
SR_DRV_HOLD_EN
- Defined:
  - PULSE holds s/r until q_fb==lvl, or until PULSE_W+TIMEOUT cycles have elapsed.
  - On a match: s/r drop at that edge, go to DONE with err=0. WAIT is skipped.
  - On expiry: s/r drop, go to DONE with err=1.
- Undefined: the fixed-width pulse and WAIT phase described above.

Test Plan:
1. Reset released with q_fb=0; req_valid=1, req_level=1 at E0 -> s=1 for 2 cycles, r=0. q_fb goes 1 during the pulse -> done=1, err=0 one cycle after E3; req_ready returns to 1 after E4.
2. q_fb=1, request level 1 -> no s/r activity; done=1, err=0 in the cycle after E0.
3. q_fb stuck at 0, request level 1 -> s pulses for 2 cycles. done=1, err=1 after E6 (2+4).
4. q_fb=1, request level 0 -> r=1 for 2 cycles, s stays 0 throughout; q_fb falls -> done with err=0. Assert s&r==0 every cycle.
5. Assert reset in the middle of PULSE -> s/r go to 0 asynchronously, busy=0, no done strobe. A new request after reset release completes normally.
6. req_valid held high continuously alternating levels 1,0,1 -> each command is accepted only when req_ready=1, commands complete in order, and extra valid cycles while busy are ignored. With SR_DRV_HOLD_EN, rerun scenario 1 with q_fb rising 1 cycle after s -> s drops at the match edge and done follows in the next cycle.
